// File: rtl/gearbox_pkg.sv
// Shared rate codes, state encoding and rate-to-replication mapping for data_rate_gearbox.
package gearbox_pkg;

    localparam logic [1:0] RATE_X4 = 2'b00;
    localparam logic [1:0] RATE_X2 = 2'b01;
    localparam logic [1:0] RATE_X1 = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } gearbox_state_e;

    // Codes at or beyond max_log2_rep (10 and 11 by default) both mean full rate.
    function automatic int rate_to_rep(input logic [1:0] rate, input int max_log2_rep);
        int rate_i;
        rate_i = int'(rate);
        return (rate_i < max_log2_rep) ? (max_log2_rep - rate_i) : 0;
    endfunction

endpackage

// File: rtl/data_rate_gearbox_chunk_replicator.sv
// Combinational chunk selector: picks chunk p of the word and repeats every bit 2^rep times.
module chunk_replicator
    import gearbox_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int MAX_LOG2_REP = 2,
    parameter int P_W          = 2,
    parameter int REP_W        = 2
) (
    input  logic [WIDTH-1:0] word,
    input  logic [P_W-1:0]   p,
    input  logic [REP_W-1:0] rep,
    output logic [WIDTH-1:0] chunk
);

    localparam int IDX_W = $clog2(WIDTH);

    logic [IDX_W-1:0] idx;

    // One candidate mapping per replication factor; p is masked so unused factors stay in range.
    always_comb begin
        chunk = '0;
        idx   = '0;
        for (int r = 0; r <= MAX_LOG2_REP; r++) begin
            if (int'(rep) == r) begin
                for (int i = 0; i < WIDTH; i++) begin
                    idx      = IDX_W'((int'(p) % (1 << r)) * (WIDTH >> r) + (i >> r));
                    chunk[i] = word[idx];
                end
            end
        end
    end

endmodule

// File: rtl/data_rate_gearbox.sv
// Rate-adapting gearbox: splits each word into 2^rep bit-replicated chunks for the serializer.
// Optional feature macro: DATA_RATE_GEARBOX_UNDERRUN_CNT_EN adds the underrun_cnt output.
module data_rate_gearbox
    import gearbox_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int MAX_LOG2_REP = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       dataRate,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
`ifdef DATA_RATE_GEARBOX_UNDERRUN_CNT_EN
    output logic [15:0]      underrun_cnt,
`endif
    input  logic             dout_ready
);

    localparam int P_W   = (MAX_LOG2_REP > 0) ? MAX_LOG2_REP : 1;
    localparam int REP_W = (MAX_LOG2_REP > 0) ? $clog2(MAX_LOG2_REP + 1) : 1;

    gearbox_state_e   state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [P_W-1:0]   p_q, p_d;
    logic [WIDTH-1:0] dout_q, dout_d;

    logic [REP_W-1:0] new_rep;
    logic [P_W-1:0]   p_next;
    logic [WIDTH-1:0] first_chunk;
    logic [WIDTH-1:0] next_chunk;
    logic             is_last;
    logic             handshake;
    logic             accept;

    assign new_rep    = REP_W'(rate_to_rep(dataRate, MAX_LOG2_REP));
    assign p_next     = p_q + 1'b1;
    assign is_last    = (int'(p_q) == ((1 << int'(rep_q)) - 1));
    assign dout_valid = (state_q == EMIT);
    assign dout       = dout_q;
    assign handshake  = dout_valid && dout_ready;
    assign accept     = din_valid && din_ready;

    // Chunk 0 of an incoming word is built straight from din so it lands in dout on accept.
    chunk_replicator #(
        .WIDTH        (WIDTH),
        .MAX_LOG2_REP (MAX_LOG2_REP),
        .P_W          (P_W),
        .REP_W        (REP_W)
    ) u_first_chunk (
        .word  (din),
        .p     ('0),
        .rep   (new_rep),
        .chunk (first_chunk)
    );

    chunk_replicator #(
        .WIDTH        (WIDTH),
        .MAX_LOG2_REP (MAX_LOG2_REP),
        .P_W          (P_W),
        .REP_W        (REP_W)
    ) u_next_chunk (
        .word  (word_q),
        .p     (p_next),
        .rep   (rep_q),
        .chunk (next_chunk)
    );

    always_comb begin
        din_ready = (state_q == IDLE) || (is_last && dout_ready);
        state_d   = state_q;
        word_d    = word_q;
        rep_d     = rep_q;
        p_d       = p_q;
        dout_d    = dout_q;
        if (accept) begin
            state_d = EMIT;
            word_d  = din;
            rep_d   = new_rep;
            p_d     = '0;
            dout_d  = first_chunk;
        end else if (handshake) begin
            if (is_last) begin
                state_d = IDLE;
                p_d     = '0;
            end else begin
                p_d    = p_next;
                dout_d = next_chunk;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            word_q  <= '0;
            rep_q   <= '0;
            p_q     <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            rep_q   <= rep_d;
            p_q     <= p_d;
            dout_q  <= dout_d;
        end
    end

`ifdef DATA_RATE_GEARBOX_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_q, underrun_cnt_d;

    // Counts serializer-ready cycles with nothing to send, saturating at all ones.
    always_comb begin
        underrun_cnt_d = underrun_cnt_q;
        if (dout_ready && !dout_valid && (underrun_cnt_q != 16'hFFFF)) begin
            underrun_cnt_d = underrun_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun_cnt_q <= '0;
        end else begin
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

    assign underrun_cnt = underrun_cnt_q;
`endif

endmodule

// File: tb/tb_data_rate_gearbox.sv
// Scoreboard bench for data_rate_gearbox at WIDTH=32, MAX_LOG2_REP=2.
module tb_data_rate_gearbox;
    import gearbox_pkg::*;

    logic        clk;
    logic        reset;
    logic [1:0]  dataRate;
    logic [31:0] din;
    logic        din_valid;
    logic        din_ready;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready;
`ifdef DATA_RATE_GEARBOX_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    int          total;
    int          bad;
    logic [31:0] sb[$];
    logic [31:0] exp;

    data_rate_gearbox #(
        .WIDTH        (32),
        .MAX_LOG2_REP (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .dataRate     (dataRate),
        .din          (din),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .dout         (dout),
        .dout_valid   (dout_valid),
`ifdef DATA_RATE_GEARBOX_UNDERRUN_CNT_EN
        .underrun_cnt (underrun_cnt),
`endif
        .dout_ready   (dout_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference chunking: chunk p takes bits [p*cw +: cw], each bit repeated 2^rep times.
    function automatic void push_word(input logic [31:0] w, input logic [1:0] rate);
        int          rep;
        int          cw;
        logic [31:0] c;
        rep = (rate == RATE_X4) ? 2 : ((rate == RATE_X2) ? 1 : 0);
        cw  = 32 >> rep;
        for (int p = 0; p < (1 << rep); p++) begin
            for (int i = 0; i < 32; i++) begin
                c[i] = w[5'(p * cw + i / (1 << rep))];
            end
            sb.push_back(c);
        end
    endfunction

    task automatic drive(input logic v, input logic [31:0] d, input logic [1:0] r, input logic rdy);
        @(negedge clk);
        din_valid  = v;
        din        = d;
        dataRate   = r;
        dout_ready = rdy;
        #1;
    endtask

    task automatic test_reset;
        drive(1'b0, 32'h0, RATE_X1, 1'b0);
        total++;
        if (din_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_din_ready got=%b exp=1", din_ready); end
        total++;
        if (dout_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_dout_valid got=%b exp=0", dout_valid); end
        total++;
        if (dout !== 32'h0) begin bad++; $display("[TB] FAIL reset_dout got=%h exp=00000000", dout); end
        reset = 1'b0;
    endtask

    task automatic test_x1;
        logic [31:0] words [4] = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h5A5AA5A5};
        for (int c = 0; c < 6; c++) begin
            drive(c < 4, (c < 4) ? words[c] : 32'h0, RATE_X1, 1'b1);
            total++;
            if (dout_valid !== (c >= 1 && c <= 4)) begin
                bad++; $display("[TB] FAIL x1_valid c=%0d got=%b exp=%b", c, dout_valid, (c >= 1 && c <= 4));
            end
            total++;
            if (din_ready !== 1'b1) begin bad++; $display("[TB] FAIL x1_din_ready c=%0d got=%b exp=1", c, din_ready); end
            if (c == 1) begin
                total++;
                if (dout !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL x1_first got=%h exp=deadbeef", dout); end
            end
            if (dout_valid && dout_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("[TB] FAIL x1_sb got=%h exp=none", dout);
                end else begin
                    exp = sb.pop_front();
                    if (dout !== exp) begin bad++; $display("[TB] FAIL x1_sb got=%h exp=%h", dout, exp); end
                end
            end
            if (din_valid && din_ready) push_word(din, dataRate);
        end
        total++;
        if (sb.size() != 0) begin bad++; $display("[TB] FAIL x1_drain got=%0d exp=0", sb.size()); end
    endtask

    task automatic test_x2;
        logic       rdy_exp [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] dexp [4] = '{32'h0, 32'h0000CC33, 32'h030C0F30, 32'h0};
        for (int c = 0; c < 4; c++) begin
            drive(c == 0, 32'h123400A5, RATE_X2, 1'b1);
            total++;
            if (din_ready !== rdy_exp[c]) begin bad++; $display("[TB] FAIL x2_din_ready c=%0d got=%b exp=%b", c, din_ready, rdy_exp[c]); end
            if (c == 1 || c == 2) begin
                total++;
                if (dout !== dexp[c]) begin bad++; $display("[TB] FAIL x2_chunk c=%0d got=%h exp=%h", c, dout, dexp[c]); end
            end
            if (dout_valid && dout_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("[TB] FAIL x2_sb got=%h exp=none", dout);
                end else begin
                    exp = sb.pop_front();
                    if (dout !== exp) begin bad++; $display("[TB] FAIL x2_sb got=%h exp=%h", dout, exp); end
                end
            end
            if (din_valid && din_ready) push_word(din, dataRate);
        end
        total++;
        if (dout_valid !== 1'b0) begin bad++; $display("[TB] FAIL x2_end_valid got=%b exp=0", dout_valid); end
    endtask

    task automatic test_x4;
        logic [31:0] dexp [6] = '{32'h0, 32'hF000000F, 32'h0, 32'h0, 32'h0, 32'h0};
        for (int c = 0; c < 6; c++) begin
            drive(c == 0, 32'h00000081, RATE_X4, 1'b1);
            total++;
            if (dout_valid !== (c >= 1 && c <= 4)) begin
                bad++; $display("[TB] FAIL x4_valid c=%0d got=%b exp=%b", c, dout_valid, (c >= 1 && c <= 4));
            end
            if (c >= 1 && c <= 4) begin
                total++;
                if (dout !== dexp[c]) begin bad++; $display("[TB] FAIL x4_chunk c=%0d got=%h exp=%h", c, dout, dexp[c]); end
            end
            if (dout_valid && dout_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("[TB] FAIL x4_sb got=%h exp=none", dout);
                end else begin
                    exp = sb.pop_front();
                    if (dout !== exp) begin bad++; $display("[TB] FAIL x4_sb got=%h exp=%h", dout, exp); end
                end
            end
            if (din_valid && din_ready) push_word(din, dataRate);
        end
    endtask

    task automatic test_stall;
        logic v;
        for (int c = 0; c < 10; c++) begin
            v = (c == 0) || (c >= 2 && c <= 7);
            drive(v, (c == 0) ? 32'h00C00F00 : 32'hA5A50001, (c == 0) ? RATE_X4 : RATE_X1,
                  !(c >= 2 && c <= 4));
            if (c >= 2 && c <= 5) begin
                total++;
                if (dout !== 32'h0000FFFF) begin bad++; $display("[TB] FAIL stall_hold c=%0d got=%h exp=0000ffff", c, dout); end
                total++;
                if (din_ready !== 1'b0) begin bad++; $display("[TB] FAIL stall_din_ready c=%0d got=%b exp=0", c, din_ready); end
            end
            if (c == 6) begin
                total++;
                if (dout !== 32'hFF000000) begin bad++; $display("[TB] FAIL stall_resume got=%h exp=ff000000", dout); end
            end
            if (c == 7) begin
                total++;
                if (din_ready !== 1'b1) begin bad++; $display("[TB] FAIL stall_last_ready got=%b exp=1", din_ready); end
            end
            if (dout_valid && dout_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("[TB] FAIL stall_sb got=%h exp=none", dout);
                end else begin
                    exp = sb.pop_front();
                    if (dout !== exp) begin bad++; $display("[TB] FAIL stall_sb got=%h exp=%h", dout, exp); end
                end
            end
            if (din_valid && din_ready) push_word(din, dataRate);
        end
        total++;
        if (sb.size() != 0) begin bad++; $display("[TB] FAIL stall_drain got=%0d exp=0", sb.size()); end
    endtask

    task automatic test_rate_change;
        int hs = 0;
        for (int c = 0; c < 7; c++) begin
            drive((c == 0) || (c >= 2 && c <= 4), (c == 0) ? 32'h12345678 : 32'hCAFEF00D,
                  (c < 2) ? RATE_X4 : RATE_X1, 1'b1);
            if (c == 5) begin
                total++;
                if (dout !== 32'hCAFEF00D) begin bad++; $display("[TB] FAIL rate_next_word got=%h exp=cafef00d", dout); end
            end
            if (dout_valid && dout_ready) begin
                hs++;
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("[TB] FAIL rate_sb got=%h exp=none", dout);
                end else begin
                    exp = sb.pop_front();
                    if (dout !== exp) begin bad++; $display("[TB] FAIL rate_sb got=%h exp=%h", dout, exp); end
                end
            end
            if (din_valid && din_ready) push_word(din, dataRate);
        end
        total++;
        if (hs != 5) begin bad++; $display("[TB] FAIL rate_chunk_count got=%0d exp=5", hs); end
    endtask

    task automatic test_back_to_back;
        for (int c = 0; c < 100; c++) begin
            if (c < 90) begin
                drive($urandom_range(0, 3) != 0, $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
            end else begin
                drive(1'b0, 32'h0, RATE_X1, 1'b1);
            end
            if (dout_valid && dout_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("[TB] FAIL b2b_sb c=%0d got=%h exp=none", c, dout);
                end else begin
                    exp = sb.pop_front();
                    if (dout !== exp) begin bad++; $display("[TB] FAIL b2b_sb c=%0d got=%h exp=%h", c, dout, exp); end
                end
            end
            if (din_valid && din_ready) push_word(din, dataRate);
        end
        total++;
        if (sb.size() != 0) begin bad++; $display("[TB] FAIL b2b_drain got=%0d exp=0", sb.size()); end
    endtask

    task automatic test_reset_mid;
        for (int c = 0; c < 4; c++) begin
            drive(c == 0, 32'h0F0FF0F0, RATE_X4, c != 3);
            if (c == 3) begin
                total++;
                if (dout_valid !== 1'b1) begin bad++; $display("[TB] FAIL mid_pre_valid got=%b exp=1", dout_valid); end
            end
        end
        reset = 1'b1;
        #1;
        total++;
        if (dout !== 32'h0) begin bad++; $display("[TB] FAIL mid_reset_dout got=%h exp=00000000", dout); end
        total++;
        if (dout_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_valid got=%b exp=0", dout_valid); end
        total++;
        if (din_ready !== 1'b1) begin bad++; $display("[TB] FAIL mid_reset_ready got=%b exp=1", din_ready); end
        sb.delete();
        drive(1'b0, 32'h0, RATE_X4, 1'b1);
        reset = 1'b0;
`ifdef DATA_RATE_GEARBOX_UNDERRUN_CNT_EN
        for (int c = 0; c < 5; c++) drive(1'b0, 32'h0, RATE_X4, 1'b1);
        total++;
        if (underrun_cnt !== 16'd5) begin bad++; $display("[TB] FAIL underrun_count got=%0d exp=5", underrun_cnt); end
        force dut.underrun_cnt_q = 16'hFFFF;
        drive(1'b0, 32'h0, RATE_X4, 1'b1);
        release dut.underrun_cnt_q;
        drive(1'b0, 32'h0, RATE_X4, 1'b1);
        drive(1'b0, 32'h0, RATE_X4, 1'b1);
        total++;
        if (underrun_cnt !== 16'hFFFF) begin bad++; $display("[TB] FAIL underrun_sat got=%h exp=ffff", underrun_cnt); end
`endif
        for (int c = 0; c < 6; c++) begin
            drive(c == 0, 32'h000000F1, RATE_X4, 1'b1);
            if (c == 1) begin
                total++;
                if (dout !== 32'hFFFF000F) begin bad++; $display("[TB] FAIL mid_restart got=%h exp=ffff000f", dout); end
            end
            if (dout_valid && dout_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("[TB] FAIL mid_sb got=%h exp=none", dout);
                end else begin
                    exp = sb.pop_front();
                    if (dout !== exp) begin bad++; $display("[TB] FAIL mid_sb got=%h exp=%h", dout, exp); end
                end
            end
            if (din_valid && din_ready) push_word(din, dataRate);
        end
        total++;
        if (sb.size() != 0) begin bad++; $display("[TB] FAIL mid_drain got=%0d exp=0", sb.size()); end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        din_valid  = 1'b0;
        din        = '0;
        dataRate   = RATE_X4;
        dout_ready = 1'b0;
        test_reset();
        test_x1();
        test_x2();
        test_x4();
        test_stall();
        test_rate_change();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
